// File: rtl/membus_burst_bridge.sv
// Cache-line membus slave to word-wide DDR master; read commands pipeline ahead of returning data.
// Latency: 1 cycle request capture, then one beat per accepted command, resp one cycle after the last beat/return.
// Backpressure: beats advance only on ddr_cmd_valid_o & ddr_cmd_ready_i. Optional MEMBUS_BRIDGE_CRITICAL_WORD_FIRST_EN.
module membus_burst_bridge #(
    parameter int addr_bits = 32,
    parameter int line_bits = 256,
    parameter int word_bits = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addr_bits-1:0] membus_addr_i,
    input  logic                 membus_read_i,
    input  logic                 membus_write_i,
    input  logic [line_bits-1:0] membus_wdata_i,
    output logic [line_bits-1:0] membus_rdata_o,
    output logic                 membus_resp_o,
    output logic                 ddr_cmd_valid_o,
    input  logic                 ddr_cmd_ready_i,
    output logic                 ddr_cmd_we_o,
    output logic [addr_bits-1:0] ddr_cmd_addr_o,
    output logic [word_bits-1:0] ddr_cmd_wdata_o,
    input  logic                 ddr_rdata_valid_i,
    input  logic [word_bits-1:0] ddr_rdata_i
);
    localparam int BEATS    = line_bits / word_bits;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_OFF = $clog2(line_bits / 8);
    localparam int WORD_OFF = $clog2(word_bits / 8);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t               state_q, state_d;
    logic [addr_bits-1:0] base_q, base_d;
    logic [line_bits-1:0] wdata_q, wdata_d;
    logic [line_bits-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]     ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0]     start_q, start_d;
    logic                 issue_done_q, issue_done_d;
    logic                 ret_done_q, ret_done_d;

    logic [CNT_W-1:0]     iss_slot, ret_slot, req_start;
    logic                 cmd_fire, ret_fire;

`ifdef MEMBUS_BRIDGE_CRITICAL_WORD_FIRST_EN
    logic unused_addr_bits;
    assign req_start        = membus_addr_i[WORD_OFF +: CNT_W];
    assign unused_addr_bits = ^membus_addr_i[WORD_OFF-1:0];
`else
    logic unused_addr_bits;
    assign req_start        = '0;
    assign unused_addr_bits = ^membus_addr_i[LINE_OFF-1:0];
`endif

    // Slot arithmetic wraps modulo BEATS through the counter width.
    assign iss_slot = start_q + issue_cnt_q;
    assign ret_slot = start_q + ret_cnt_q;

    always_comb begin
        ddr_cmd_valid_o = (state_q == WRITE) || ((state_q == READ) && !issue_done_q);
        ddr_cmd_we_o    = (state_q == WRITE);
        ddr_cmd_addr_o  = '0;
        ddr_cmd_wdata_o = '0;
        if (ddr_cmd_valid_o) begin
            ddr_cmd_addr_o = base_q | (addr_bits'(iss_slot) << WORD_OFF);
        end
        if (ddr_cmd_we_o) begin
            ddr_cmd_wdata_o = wdata_q[iss_slot*word_bits +: word_bits];
        end
    end

    assign membus_resp_o  = (state_q == RESP);
    assign membus_rdata_o = rdata_q;
    assign cmd_fire       = ddr_cmd_valid_o && ddr_cmd_ready_i;
    assign ret_fire       = (state_q == READ) && ddr_rdata_valid_i && !ret_done_q;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        start_d      = start_q;
        issue_done_d = issue_done_q;
        ret_done_d   = ret_done_q;

        case (state_q)
            IDLE: begin
                issue_cnt_d  = '0;
                ret_cnt_d    = '0;
                issue_done_d = 1'b0;
                ret_done_d   = 1'b0;
                if (membus_write_i || membus_read_i) begin
                    base_d  = {membus_addr_i[addr_bits-1:LINE_OFF], {LINE_OFF{1'b0}}};
                    wdata_d = membus_wdata_i;
                end
                if (membus_write_i) begin
                    state_d = WRITE;
                    start_d = '0;
                end else if (membus_read_i) begin
                    state_d = READ;
                    start_d = req_start;
                end
            end
            WRITE: begin
                if (cmd_fire) begin
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                    if (issue_cnt_q == CNT_LAST) begin
                        state_d = RESP;
                    end
                end
            end
            READ: begin
                if (cmd_fire) begin
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                    if (issue_cnt_q == CNT_LAST) begin
                        issue_done_d = 1'b1;
                    end
                end
                // Returns may arrive in the same cycle a later command is accepted.
                if (ret_fire) begin
                    rdata_d[ret_slot*word_bits +: word_bits] = ddr_rdata_i;
                    ret_cnt_d = ret_cnt_q + CNT_ONE;
                    if (ret_cnt_q == CNT_LAST) begin
                        ret_done_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            start_q      <= '0;
            issue_done_q <= 1'b0;
            ret_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            start_q      <= start_d;
            issue_done_q <= issue_done_d;
            ret_done_q   <= ret_done_d;
        end
    end
endmodule

// File: tb/tb_membus_burst_bridge.sv
// Directed bench for membus_burst_bridge with a 2-cycle in-order DDR read responder.
module tb_membus_burst_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  membus_addr_i;
    logic         membus_read_i;
    logic         membus_write_i;
    logic [255:0] membus_wdata_i;
    logic [255:0] membus_rdata_o;
    logic         membus_resp_o;
    logic         ddr_cmd_valid_o;
    logic         ddr_cmd_ready_i;
    logic         ddr_cmd_we_o;
    logic [31:0]  ddr_cmd_addr_o;
    logic [31:0]  ddr_cmd_wdata_o;
    logic         ddr_rdata_valid_i;
    logic [31:0]  ddr_rdata_i;

    always #5 clk = ~clk;

    membus_burst_bridge dut (
        .clk              (clk),
        .rst              (rst),
        .membus_addr_i    (membus_addr_i),
        .membus_read_i    (membus_read_i),
        .membus_write_i   (membus_write_i),
        .membus_wdata_i   (membus_wdata_i),
        .membus_rdata_o   (membus_rdata_o),
        .membus_resp_o    (membus_resp_o),
        .ddr_cmd_valid_o  (ddr_cmd_valid_o),
        .ddr_cmd_ready_i  (ddr_cmd_ready_i),
        .ddr_cmd_we_o     (ddr_cmd_we_o),
        .ddr_cmd_addr_o   (ddr_cmd_addr_o),
        .ddr_cmd_wdata_o  (ddr_cmd_wdata_o),
        .ddr_rdata_valid_i(ddr_rdata_valid_i),
        .ddr_rdata_i      (ddr_rdata_i)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int resp_cnt   = 0;
    int resp_cyc   = -1;
    int last_fire_cyc = -1;
    int last_ret_cyc  = -1;
    int stall_viol = 0;
    bit toggle_rdy = 1'b0;
    bit stray      = 1'b0;
    bit resp_seen  = 1'b0;
    logic [31:0]  rd_base = 32'h0;
    logic [255:0] resp_rdata = '0;
    logic [31:0]  log_addr[$];
    logic [31:0]  log_wdata[$];
    logic         log_we[$];
    logic [31:0]  pend_addr[$];
    int           pend_due[$];
    logic         prev_stall = 1'b0;
    logic         prev_we    = 1'b0;
    logic [31:0]  prev_addr  = '0;
    logic [31:0]  prev_wdata = '0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] b);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = b + 32'(k);
        return l;
    endfunction

    // Observe the settled cycle, cross the edge, then drive the next cycle's inputs.
    task automatic step();
        if (!rst) begin
            if (prev_stall && (!ddr_cmd_valid_o || ddr_cmd_addr_o !== prev_addr ||
                ddr_cmd_wdata_o !== prev_wdata || ddr_cmd_we_o !== prev_we)) stall_viol++;
            prev_stall = ddr_cmd_valid_o && !ddr_cmd_ready_i;
            prev_addr  = ddr_cmd_addr_o;
            prev_wdata = ddr_cmd_wdata_o;
            prev_we    = ddr_cmd_we_o;
            if (ddr_cmd_valid_o && ddr_cmd_ready_i) begin
                log_addr.push_back(ddr_cmd_addr_o);
                log_wdata.push_back(ddr_cmd_wdata_o);
                log_we.push_back(ddr_cmd_we_o);
                last_fire_cyc = cyc;
                if (!ddr_cmd_we_o) begin
                    pend_addr.push_back(ddr_cmd_addr_o);
                    pend_due.push_back(cyc + 2);
                end
            end
            if (membus_resp_o) begin
                resp_cnt++;
                resp_seen  = 1'b1;
                resp_cyc   = cyc;
                resp_rdata = membus_rdata_o;
            end
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        ddr_cmd_ready_i   = toggle_rdy ? ~ddr_cmd_ready_i : 1'b1;
        ddr_rdata_valid_i = 1'b0;
        ddr_rdata_i       = '0;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (stray) begin
            ddr_rdata_valid_i = 1'b1;
            ddr_rdata_i       = 32'hDEAD;
            stray             = 1'b0;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            ddr_rdata_valid_i = 1'b1;
            ddr_rdata_i       = rd_base + ((pend_addr[0] >> 2) & 32'h7);
            pend_addr.pop_front();
            pend_due.pop_front();
            last_ret_cyc = cyc;
        end
    endtask

    task automatic start_txn();
        log_addr.delete();
        log_wdata.delete();
        log_we.delete();
        resp_cnt  = 0;
        resp_seen = 1'b0;
        stall_viol = 0;
    endtask

    task automatic run_to_resp(input string tag);
        for (int i = 0; i < 100 && !resp_seen; i++) step();
        check({tag, "_resp_seen"}, 256'(resp_seen), 256'd1);
        membus_read_i  = 1'b0;
        membus_write_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check({tag, "_resp_cnt"}, 256'(resp_cnt), 256'd1);
    endtask

    task automatic check_cmds(input string tag, input logic [31:0] base, input logic we,
                              input logic [31:0] wbase, input int first);
        check({tag, "_ncmd"}, 256'(log_addr.size()), 256'd8);
        for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
            check({tag, "_addr"}, 256'(log_addr[k]), 256'(base + 32'(4 * ((first + k) % 8))));
            check({tag, "_we"}, 256'(log_we[k]), 256'(we));
            if (we) check({tag, "_wdata"}, 256'(log_wdata[k]), 256'(wbase + 32'(k)));
        end
    endtask

    initial begin
        rst               = 1'b1;
        membus_addr_i     = '0;
        membus_read_i     = 1'b0;
        membus_write_i    = 1'b0;
        membus_wdata_i    = '0;
        ddr_cmd_ready_i   = 1'b1;
        ddr_rdata_valid_i = 1'b0;
        ddr_rdata_i       = '0;
        step();
        step();
        check("rst_resp", 256'(membus_resp_o), 256'd0);
        check("rst_valid", 256'(ddr_cmd_valid_o), 256'd0);
        check("rst_we", 256'(ddr_cmd_we_o), 256'd0);
        check("rst_addr", 256'(ddr_cmd_addr_o), 256'd0);
        check("rst_wdata", 256'(ddr_cmd_wdata_o), 256'd0);
        check("rst_rdata", membus_rdata_o, 256'd0);
        rst = 1'b0;
        step();

        // 1: line write at 0x1000
        start_txn();
        membus_addr_i  = 32'h1000;
        membus_wdata_i = line_of(32'hA0);
        membus_write_i = 1'b1;
        run_to_resp("t1");
        check_cmds("t1", 32'h1000, 1'b1, 32'hA0, 0);
        check("t1_resp_after_last", 256'(resp_cyc), 256'(last_fire_cyc + 1));

        // 2: line read at 0x2000, ready held high
        start_txn();
        rd_base       = 32'hB0;
        membus_addr_i = 32'h2000;
        membus_read_i = 1'b1;
        run_to_resp("t2");
        check_cmds("t2", 32'h2000, 1'b0, 32'h0, 0);
        check("t2_rdata", resp_rdata, line_of(32'hB0));
        check("t2_resp_after_ret", 256'(resp_cyc), 256'(last_ret_cyc + 1));

        // 3: read with ready toggling
        start_txn();
        toggle_rdy    = 1'b1;
        rd_base       = 32'hC0;
        membus_addr_i = 32'h2404;
        membus_read_i = 1'b1;
        run_to_resp("t3");
        toggle_rdy = 1'b0;
        check_cmds("t3", 32'h2400, 1'b0, 32'h0, 0);
        check("t3_rdata", resp_rdata, line_of(32'hC0));
        check("t3_stall_stable", 256'(stall_viol), 256'd0);

        // 4: read and write together, write wins
        start_txn();
        membus_addr_i  = 32'h3000;
        membus_wdata_i = line_of(32'hD0);
        membus_read_i  = 1'b1;
        membus_write_i = 1'b1;
        run_to_resp("t4");
        check_cmds("t4", 32'h3000, 1'b1, 32'hD0, 0);
        check("t4_rdata_kept", membus_rdata_o, line_of(32'hC0));
        stray = 1'b1;
        step();
        step();
        check("t4_stray_valid", 256'(ddr_cmd_valid_o), 256'd0);
        check("t4_stray_resp", 256'(resp_cnt), 256'd1);
        check("t4_stray_rdata", membus_rdata_o, line_of(32'hC0));

        // 5: reset after 3 read beats, then a clean read
        start_txn();
        rd_base       = 32'hE0;
        membus_addr_i = 32'h2800;
        membus_read_i = 1'b1;
        for (int i = 0; i < 50 && log_addr.size() < 3; i++) step();
        check("t5_beats_before_rst", 256'(log_addr.size() >= 3), 256'd1);
        rst           = 1'b1;
        membus_read_i = 1'b0;
        step();
        check("t5_rst_valid", 256'(ddr_cmd_valid_o), 256'd0);
        check("t5_rst_addr", 256'(ddr_cmd_addr_o), 256'd0);
        check("t5_rst_rdata", membus_rdata_o, 256'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("t5_no_resp", 256'(resp_cnt), 256'd0);
        check("t5_idle_valid", 256'(ddr_cmd_valid_o), 256'd0);
        start_txn();
        rd_base       = 32'hF0;
        membus_addr_i = 32'h4000;
        membus_read_i = 1'b1;
        run_to_resp("t5b");
        check_cmds("t5b", 32'h4000, 1'b0, 32'h0, 0);
        check("t5b_rdata", resp_rdata, line_of(32'hF0));

        // 6: read at 0x501C; start word depends on the build option
        start_txn();
        rd_base       = 32'h10;
        membus_addr_i = 32'h501C;
        membus_read_i = 1'b1;
        run_to_resp("t6");
`ifdef MEMBUS_BRIDGE_CRITICAL_WORD_FIRST_EN
        check_cmds("t6", 32'h5000, 1'b0, 32'h0, 7);
`else
        check_cmds("t6", 32'h5000, 1'b0, 32'h0, 0);
`endif
        check("t6_rdata", resp_rdata, line_of(32'h10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
